fifo_rd_stream: RTL and testbench
=================================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of each FIFO word and of the output stream data.
REQ-002 SHALL have port rclk  input  1  read-domain clock; all state updates on its rising edge.
REQ-003 SHALL have port rrst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port empty  input  1  registered FIFO-empty flag from the read-pointer block.
REQ-005 SHALL have port rdata  input  DATA_WIDTH  FIFO memory word at the current read address, combinationally valid while empty=0.
REQ-006 SHALL have port rinc  output  1  pop request to the read-pointer block.
REQ-007 SHALL have port m_valid  output  1  output stream word valid.
REQ-008 SHALL have port m_ready  input  1  downstream accepts the word.
REQ-009 SHALL have port m_data  output  DATA_WIDTH  output stream word.
REQ-010 SHALL have port occupancy  output  2  words held in the internal buffer (0..2).

Function
REQ-011 SHALL hold up to 2 words in an internal in-order buffer; state = occupancy: S0 (0), S1 (1), S2 (2).
REQ-012 SHALL drive rinc = !empty && (occupancy != 2) && !rrst; rinc SHALL NOT depend combinationally on m_ready.
REQ-013 SHALL capture rdata into the buffer tail on every rclk edge where rinc=1 (push).
REQ-014 SHALL drive m_valid = (occupancy != 0) and m_data = buffer head, both from registers only.
REQ-015 SHALL pop the head on an edge where m_valid && m_ready.
REQ-016 Transitions: S0 push -> S1; S1 push only -> S2; S1 pop only -> S0; S1 push+pop -> S1 with new head = old tail-slot word; S2 pop -> S1; S2 never pushes; no event -> stay.
REQ-017 SHALL sustain one word per cycle when empty=0 and m_ready=1 continuously (steady state S1).
REQ-018 Latency: word popped via rinc at edge N SHALL appear on m_data with m_valid=1 from edge N onward (visible in cycle N+1).
REQ-019 m_data and m_valid SHALL remain stable while m_valid=1 and m_ready=0.
REQ-020 m_ready while m_valid=0 SHALL have no effect.
REQ-021 empty asserting while occupancy>0 SHALL NOT disturb buffered words; they drain normally.

Reset
REQ-022 While rrst=1 at an rclk edge: occupancy=0, m_valid=0, buffer pointers cleared; rinc SHALL be 0 combinationally for the whole reset cycle.
REQ-023 Reset mid-operation SHALL discard buffered words; no partial word SHALL be presented after reset.
REQ-024 m_data value during reset is don't-care but SHALL NOT be X after the first reset edge (clear to 0).

Configuration
REQ-025 Macro FIFO_RD_STREAM_STATS_EN, when defined, SHALL add output words_out (16 bits): count of m_valid&&m_ready handshakes, wrapping 0xFFFF->0x0000, cleared by rrst.
REQ-026 Without FIFO_RD_STREAM_STATS_EN, port words_out and its counter SHALL NOT exist; all other behaviour identical.

Structure
REQ-027 Shared package fifo_pkg SHALL hold the default DATA_WIDTH constant and the occupancy state encoding (S0=0, S1=1, S2=2).
REQ-028 Statistics counter SHALL be a sub-module fifo_rd_stats, instantiated only under FIFO_RD_STREAM_STATS_EN; the buffer is inline.

Verification
REQ-029 Reset with empty=0: assert rrst 2 cycles -> rinc=0, m_valid=0, occupancy=0 throughout; first rinc=1 on cycle after rrst deasserts.
REQ-030 Stream 0x11,0x22,0x33 with m_ready=1 -> m_data 0x11,0x22,0x33 on consecutive cycles, occupancy steady 1, no gaps.
REQ-031 Backpressure: m_ready=0, FIFO holds 0xA0..0xA3 -> occupancy reaches 2, rinc drops to 0, m_data holds 0xA0; raise m_ready -> 0xA0,0xA1,0xA2,0xA3 in order, none lost or duplicated.
REQ-032 Simultaneous push/pop in S1 (head 0x55, incoming 0x66, m_ready=1) -> next cycle occupancy=1, m_data=0x66.
REQ-033 Reset mid-stream with occupancy=2 -> next cycle m_valid=0, occupancy=0; subsequent words start with next FIFO word.
REQ-034 With FIFO_RD_STREAM_STATS_EN: 65537 handshakes after reset -> words_out=0x0001.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO read-side stream adapter: default word width
// and the internal buffer occupancy encoding.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_WIDTH = 8;

  // Occupancy of the two-word skid buffer; the encoding equals the word count.
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } occ_e;

endpackage

// File: rtl/fifo_rd_stats.sv
// Handshake counter for the read stream; wraps at 16 bits, cleared by reset.
module fifo_rd_stats (
  input  logic        rclk,
  input  logic        rrst,
  input  logic        hs,
  output logic [15:0] words_out
);

  logic [15:0] count_q;

  // Count accepted output words; natural 16-bit wrap.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      count_q <= '0;
    end else if (hs) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign words_out = count_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter turning a FIFO (empty/rdata/rinc) into a valid/ready stream
// through a two-word in-order buffer. rinc never looks at m_ready, so the pop
// path toward the pointer block stays short; the second slot absorbs the word
// fetched in the cycle a stall is first seen.
// Optional build macro: FIFO_RD_STREAM_STATS_EN adds the words_out handshake count.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            occupancy
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [15:0]           words_out
`endif
);

  occ_e                  occ_q, occ_d;
  logic                  rd_ptr_q, wr_ptr_q;
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  push, pop;

  assign rinc      = !empty && (occ_q != S2) && !rrst;
  assign push      = rinc;
  assign m_valid   = (occ_q != S0);
  assign pop       = m_valid && m_ready;
  assign m_data    = mem_q[rd_ptr_q];
  assign occupancy = occ_q;

  // Occupancy next state from push/pop events.
  always_comb begin
    occ_d = occ_q;
    unique case (occ_q)
      S0: if (push) occ_d = S1;
      S1: begin
        if (push && !pop) occ_d = S2;
        else if (pop && !push) occ_d = S0;
      end
      S2: if (pop) occ_d = S1;
      default: occ_d = S0;
    endcase
  end

  // Occupancy and ring pointers.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      occ_q    <= S0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Buffer storage; cleared on reset so m_data is never X afterwards.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= rdata;
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  fifo_rd_stats u_stats (
    .rclk      (rclk),
    .rrst      (rrst),
    .hs        (pop),
    .words_out (words_out)
  );
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream. The FIFO side is a word queue: empty and
// rdata reflect its head, and a word leaves it on each edge where rinc was 1.
// Build with FIFO_RD_STREAM_STATS_EN to exercise the words_out counter too.
module tb_fifo_rd_stream;

  localparam int unsigned W = 8;

  logic         rclk;
  logic         rrst;
  logic         empty;
  logic [W-1:0] rdata;
  logic         rinc;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic [1:0]   occupancy;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [15:0]  words_out;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] src [$];

  fifo_rd_stream #(.DATA_WIDTH(W)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .empty     (empty),
    .rdata     (rdata),
    .rinc      (rinc),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .occupancy (occupancy)
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .words_out (words_out)
`endif
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    empty = (src.size() == 0);
    rdata = empty ? '0 : src[0];
    #1;
  endtask

  // One clock: pop the FIFO model if rinc was high at the edge, then settle.
  task automatic tick();
    logic         pushed;
    logic [W-1:0] tmp;
    pushed = rinc;
    @(posedge rclk);
    #1;
    if (pushed && src.size() > 0) tmp = src.pop_front();
    drive_src();
  endtask

  task automatic check_out(input string tag, input logic v, input logic [W-1:0] d,
                           input logic [1:0] occ);
    check_eq({tag, ".valid"}, {31'd0, m_valid}, {31'd0, v});
    if (v) check_eq({tag, ".data"}, {24'd0, m_data}, {24'd0, d});
    check_eq({tag, ".occ"}, {30'd0, occupancy}, {30'd0, occ});
  endtask

  initial begin
    // Reset with a non-empty FIFO: no pops, buffer stays empty.
    rrst = 1'b1; m_ready = 1'b1;
    src = '{8'h01, 8'h02};
    drive_src();
    check_eq("rst.rinc_comb", {31'd0, rinc}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("rst.rinc", {31'd0, rinc}, 32'd0);
      check_out("rst", 1'b0, 8'h00, 2'd0);
      check_eq("rst.data_zero", {24'd0, m_data}, 32'd0);
    end
    rrst = 1'b0; #1;
    check_eq("rst.first_rinc", {31'd0, rinc}, 32'd1);
    tick(); check_out("post_rst0", 1'b1, 8'h01, 2'd1);
    tick(); check_out("post_rst1", 1'b1, 8'h02, 2'd1);
    tick(); check_out("post_rst2", 1'b0, 8'h00, 2'd0);

    // Full-rate stream, steady single-word occupancy.
    src = '{8'h11, 8'h22, 8'h33}; drive_src();
    tick(); check_out("str0", 1'b1, 8'h11, 2'd1);
    tick(); check_out("str1", 1'b1, 8'h22, 2'd1);
    tick(); check_out("str2", 1'b1, 8'h33, 2'd1);
    tick(); check_out("str3", 1'b0, 8'h00, 2'd0);
    // m_ready while idle changes nothing.
    tick(); check_out("idle_ready", 1'b0, 8'h00, 2'd0);

    // Backpressure fills both slots, then drains in order.
    m_ready = 1'b0;
    src = '{8'hA0, 8'hA1, 8'hA2, 8'hA3}; drive_src();
    tick(); check_out("bp0", 1'b1, 8'hA0, 2'd1);
    tick(); check_out("bp1", 1'b1, 8'hA0, 2'd2);
    check_eq("bp1.rinc", {31'd0, rinc}, 32'd0);
    tick(); check_out("bp2", 1'b1, 8'hA0, 2'd2);
    check_eq("bp2.rinc", {31'd0, rinc}, 32'd0);
    m_ready = 1'b1; #1;
    tick(); check_out("dr0", 1'b1, 8'hA1, 2'd1);
    tick(); check_out("dr1", 1'b1, 8'hA2, 2'd1);
    tick(); check_out("dr2", 1'b1, 8'hA3, 2'd1);
    tick(); check_out("dr3", 1'b0, 8'h00, 2'd0);

    // Push and pop on the same edge in S1.
    m_ready = 1'b0;
    src = '{8'h55}; drive_src();
    tick(); check_out("pp0", 1'b1, 8'h55, 2'd1);
    src.push_back(8'h66); drive_src();
    m_ready = 1'b1; #1;
    tick(); check_out("pp1", 1'b1, 8'h66, 2'd1);
    tick(); check_out("pp2", 1'b0, 8'h00, 2'd0);

    // Reset with both slots full discards them.
    m_ready = 1'b0;
    src = '{8'hB0, 8'hB1, 8'hB2, 8'hB3}; drive_src();
    tick(); tick(); check_out("mr_full", 1'b1, 8'hB0, 2'd2);
    rrst = 1'b1; #1;
    check_eq("mr.rinc_comb", {31'd0, rinc}, 32'd0);
    tick(); check_out("mr_rst", 1'b0, 8'h00, 2'd0);
    check_eq("mr.data_zero", {24'd0, m_data}, 32'd0);
    rrst = 1'b0; m_ready = 1'b1; #1;
    tick(); check_out("mr_after0", 1'b1, 8'hB2, 2'd1);
    tick(); check_out("mr_after1", 1'b1, 8'hB3, 2'd1);
    tick(); check_out("mr_after2", 1'b0, 8'h00, 2'd0);

`ifdef FIFO_RD_STREAM_STATS_EN
    // 65537 handshakes after reset wrap the counter to 1.
    begin
      int hs;
      rrst = 1'b1; src = '{8'h00, 8'h01}; drive_src();
      tick();
      check_eq("stats.clear", {16'd0, words_out}, 32'd0);
      rrst = 1'b0; m_ready = 1'b1; #1;
      hs = 0;
      for (int c = 0; c < 70000 && hs < 65537; c++) begin
        if (m_valid && m_ready) hs++;
        while (src.size() < 2) src.push_back(W'(c));
        drive_src();
        tick();
      end
      check_eq("stats.hs_count", hs, 32'd65537);
      check_eq("stats.wrap", {16'd0, words_out}, 32'd1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
